// File: rtl/key_event_counter.sv
// key_event_counter: debounced push-button event counter/accumulator with hex display
module key_event_counter #(
  parameter int SW_WIDTH        = 10,
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MODE            = 0,
  parameter int SATURATE        = 0
) (
  input  logic                    clk100_i,
  input  logic                    rst_i,
  input  logic [SW_WIDTH-1:0]     sw_i,
  input  logic [2:0]              key_i,
  output logic [SW_WIDTH-1:0]     ledr_o,
  output logic [4*NUM_DIGITS-1:0] count_o,
  output logic                    ovf_o,
  output logic [7*NUM_DIGITS-1:0] hex_o
);
  localparam int CW  = 4 * NUM_DIGITS;
  localparam int DCW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW  = (SW_WIDTH > CW ? SW_WIDTH : CW) + 1;
  localparam logic [DCW-1:0] DC_LAST = DCW'(DEBOUNCE_CYCLES - 1);

  logic [2:0]            k1_q, k2_q, st_q, st_d;
  logic [2:0][DCW-1:0]   dc_q, dc_d;
  logic [SW_WIDTH-1:0]   sw1_q, sw2_q, ledr_q, ledr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [AW-1:0]         sum;
  logic                  press, clear, carry;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  endfunction

  // A key level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    st_d = st_q;
    dc_d = '0;
    for (int i = 0; i < 3; i++) begin
      st_d[i] = (k2_q[i] != st_q[i] && dc_q[i] == DC_LAST) ? k2_q[i] : st_q[i];
      dc_d[i] = (k2_q[i] == st_q[i] || dc_q[i] == DC_LAST) ? '0 : dc_q[i] + 1'b1;
    end
  end

  always_comb begin
    press   = st_q[0] & ~st_d[0];
    clear   = st_q[2] & ~st_d[2];
    sum     = (MODE == 1) ? AW'(count_q) + AW'(sw2_q) : AW'(count_q) + AW'(1);
    carry   = |sum[AW-1:CW];
    count_d = clear ? '0 : !press ? count_q : (carry && SATURATE != 0) ? '1 : sum[CW-1:0];
    ovf_d   = clear ? 1'b0 : ovf_q | (press & carry);
    ledr_d  = (press && !clear) ? sw2_q : ledr_q;
    hex_d   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) hex_d[7*i +: 7] = seg(count_q[4*i +: 4]);
  end

  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      k1_q    <= '1;
      k2_q    <= '1;
      st_q    <= '1;
      dc_q    <= '0;
      sw1_q   <= '0;
      sw2_q   <= '0;
      ledr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      hex_q   <= {NUM_DIGITS{7'b1000000}};
    end else begin
      k1_q    <= key_i;
      k2_q    <= k1_q;
      st_q    <= st_d;
      dc_q    <= dc_d;
      sw1_q   <= sw_i;
      sw2_q   <= sw1_q;
      ledr_q  <= ledr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      hex_q   <= hex_d;
    end
  end

  assign ledr_o  = ledr_q;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign hex_o   = hex_q;
endmodule

// File: tb/tb_key_event_counter.sv
// tb_key_event_counter: three configurations share stimulus; a behavioural model predicts each every cycle
module tb_key_event_counter;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  logic [9:0] sw;
  logic [2:0] key;

  logic [15:0] count0;
  logic [7:0]  count1, count2;
  logic [27:0] hex0;
  logic [13:0] hex1, hex2;
  logic [9:0]  ledr0, ledr1, ledr2;
  logic        ovf0, ovf1, ovf2;

  key_event_counter u0 (
    .clk100_i(clk), .rst_i(rst), .sw_i(sw), .key_i(key),
    .ledr_o(ledr0), .count_o(count0), .ovf_o(ovf0), .hex_o(hex0)
  );
  key_event_counter #(.NUM_DIGITS(2), .MODE(1)) u1 (
    .clk100_i(clk), .rst_i(rst), .sw_i(sw), .key_i(key),
    .ledr_o(ledr1), .count_o(count1), .ovf_o(ovf1), .hex_o(hex1)
  );
  key_event_counter #(.NUM_DIGITS(2), .MODE(1), .SATURATE(1)) u2 (
    .clk100_i(clk), .rst_i(rst), .sw_i(sw), .key_i(key),
    .ledr_o(ledr2), .count_o(count2), .ovf_o(ovf2), .hex_o(hex2)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
          7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  function automatic logic [27:0] hexof(input longint v, input int nd);
    logic [27:0] h = '0;
    for (int i = 0; i < nd; i++) h[7*i +: 7] = seg(4'((v >> (4*i)) & 15));
    return h;
  endfunction

  function automatic int cw_of(input int c);
    return c == 0 ? 16 : 8;
  endfunction

  // Behavioural model: pin sampling delay, run-length debounce, integer arithmetic for counting
  bit [2:0]    ms1, ms2, mst, nst;
  int          mrun [3];
  bit [9:0]    msw1, msw2;
  longint      mcount [3];
  bit          movf [3];
  bit [9:0]    mledr [3];
  logic [27:0] mhex [3];
  bit          mvalid = 0, mpress, mclr;
  longint      msum, mlim;

  always @(posedge clk) begin
    if (rst) begin
      ms1 = '1; ms2 = '1; mst = '1; msw1 = '0; msw2 = '0;
      for (int k = 0; k < 3; k++) mrun[k] = 0;
      for (int c = 0; c < 3; c++) begin
        mcount[c] = 0; movf[c] = 0; mledr[c] = '0; mhex[c] = hexof(0, cw_of(c) / 4);
      end
      mvalid = 1;
    end else begin
      nst = mst;
      for (int k = 0; k < 3; k++) begin
        if (ms2[k] != mst[k]) begin
          mrun[k]++;
          if (mrun[k] == D) begin nst[k] = ms2[k]; mrun[k] = 0; end
        end else mrun[k] = 0;
      end
      mpress = mst[0] && !nst[0];
      mclr   = mst[2] && !nst[2];
      for (int c = 0; c < 3; c++) begin
        mhex[c] = hexof(mcount[c], cw_of(c) / 4);
        mlim = longint'(1) << cw_of(c);
        if (mclr) begin
          mcount[c] = 0; movf[c] = 0;
        end else if (mpress) begin
          msum = mcount[c] + (c == 0 ? 1 : longint'(msw2));
          mledr[c] = msw2;
          if (msum >= mlim) begin
            movf[c] = 1;
            mcount[c] = (c == 2) ? mlim - 1 : msum % mlim;
          end else mcount[c] = msum;
        end
      end
      mst = nst; ms2 = ms1; ms1 = key; msw2 = msw1; msw1 = sw;
    end
  end

  logic [31:0] cnt_a [3], hex_a [3], ledr_a [3], ovf_a [3];
  assign cnt_a[0] = 32'(count0);  assign cnt_a[1] = 32'(count1);  assign cnt_a[2] = 32'(count2);
  assign hex_a[0] = 32'(hex0);    assign hex_a[1] = 32'(hex1);    assign hex_a[2] = 32'(hex2);
  assign ledr_a[0] = 32'(ledr0);  assign ledr_a[1] = 32'(ledr1);  assign ledr_a[2] = 32'(ledr2);
  assign ovf_a[0] = 32'(ovf0);    assign ovf_a[1] = 32'(ovf1);    assign ovf_a[2] = 32'(ovf2);

  always @(negedge clk) begin
    if (mvalid) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("cfg%0d count", c), cnt_a[c], 32'(mcount[c]));
        chk($sformatf("cfg%0d ledr", c), ledr_a[c], 32'(mledr[c]));
        chk($sformatf("cfg%0d ovf", c), ovf_a[c], 32'(movf[c]));
        chk($sformatf("cfg%0d hex", c), hex_a[c], 32'(mhex[c]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input int k, input int hold);
    key[k] = 1'b0;
    cyc(hold);
    key[k] = 1'b1;
    cyc(D + 4);
  endtask

  initial begin
    rst = 1'b1; key = 3'b111; sw = '0;
    cyc(3);
    rst = 1'b0;
    chk("reset count", 32'(count0), 32'h0);
    chk("reset ledr", 32'(ledr0), 32'h0);
    chk("reset ovf", 32'(ovf0), 32'h0);
    chk("reset hex", 32'(hex0), 32'({4{7'b1000000}}));

    key[0] = 1'b0;
    cyc(5);
    chk("latency edge5", 32'(count0), 32'h0);
    cyc(1);
    chk("latency edge6", 32'(count0), 32'h1);
    chk("hex lags count", 32'(hex0[6:0]), 32'(7'b1000000));
    cyc(1);
    chk("hex digit0", 32'(hex0[6:0]), 32'(7'b1111001));
    chk("hex upper", 32'(hex0[27:7]), 32'({3{7'b1000000}}));
    cyc(13);
    key[0] = 1'b1;
    cyc(10);
    chk("single event", 32'(count0), 32'h1);

    key[0] = 1'b0; cyc(3); key[0] = 1'b1; cyc(2); key[0] = 1'b0; cyc(3); key[0] = 1'b1;
    cyc(10);
    chk("glitch rejected", 32'(count0), 32'h1);
    tap(0, 10);
    chk("after glitch", 32'(count0), 32'h2);

    tap(2, 8);
    chk("clear", 32'(count1), 32'h0);
    sw = 10'h0F0; tap(0, 8);
    chk("acc F0", 32'(count1), 32'hF0);
    chk("sat F0", 32'(count2), 32'hF0);
    sw = 10'h020; tap(0, 8);
    chk("wrap", 32'(count1), 32'h10);
    chk("wrap ovf", 32'(ovf1), 32'h1);
    chk("wrap ledr", 32'(ledr1), 32'h020);
    chk("sat", 32'(count2), 32'hFF);
    chk("sat ovf", 32'(ovf2), 32'h1);
    sw = 10'h005; tap(0, 8);
    chk("sat hold", 32'(count2), 32'hFF);
    chk("wrap more", 32'(count1), 32'h15);
    chk("mode0 count", 32'(count0), 32'h3);

    tap(2, 8);
    sw = 10'h3A5;
    repeat (5) tap(0, 8);
    chk("five", 32'(count0), 32'h5);
    sw = 10'h111;
    key = 3'b010;
    cyc(8);
    key = 3'b111;
    cyc(D + 4);
    chk("simul count", 32'(count0), 32'h0);
    chk("simul ovf", 32'(ovf1), 32'h0);
    chk("simul ledr", 32'(ledr0), 32'h3A5);

    key[0] = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(D + 1);
    chk("rst debounce early", 32'(count0), 32'h0);
    cyc(1);
    chk("rst debounce event", 32'(count0), 32'h1);
    key[0] = 1'b1;
    cyc(10);

    for (int n = 0; n < 40; n++) begin
      int k;
      sw = 10'($urandom_range(0, 1023));
      k = ($urandom_range(0, 4) == 0) ? 2 : 0;
      key[k] = 1'b0;
      cyc($urandom_range(1, 12));
      key[k] = 1'b1;
      cyc($urandom_range(1, 8));
    end
    cyc(12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
